// File: rtl/memwb_pkg.sv
// Shared types for the Memory-to-Writeback boundary: bundle layout and skid occupancy states.
package memwb_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned RD_W_DEF   = 6;
   localparam int unsigned RSRC_W_DEF = 2;

   typedef struct packed {
      logic                  RegWrite;
      logic [RSRC_W_DEF-1:0] ResultSrc;
      logic [DATA_W_DEF-1:0] ALUOut;
      logic [DATA_W_DEF-1:0] ReadData;
      logic [RD_W_DEF-1:0]   RD;
      logic [DATA_W_DEF-1:0] PCPlus4;
   } memwb_bundle_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

   // Flat payload width; field order matches memwb_bundle_t, RegWrite in the MSB.
   function automatic int unsigned bundle_width(input int unsigned data_w,
                                                input int unsigned rd_w,
                                                input int unsigned rsrc_w);
      return 1 + rsrc_w + 3 * data_w + rd_w;
   endfunction

endpackage

// File: rtl/memwb_skid_stage_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready depends on registered state only.
module skid_buffer
   import memwb_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_e  state;
   skid_state_e  state_next;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         in_fire;
   logic         out_fire;
   logic         load_main_in;
   logic         load_main_skid;
   logic         load_skid;

   assign out_valid = (state != EMPTY);
   assign in_ready  = (state != TWO);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_data  = main_q;

   always_comb begin
      state_next     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      // Flush drops both entries and the incoming bundle; payload stays stale.
      if (flush) begin
         state_next = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_fire) begin
                  load_main_in = 1'b1;
                  state_next   = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (out_fire) begin
                  state_next = EMPTY;
               end else if (in_fire) begin
                  load_skid  = 1'b1;
                  state_next = TWO;
               end
            end
            TWO: begin
               if (out_fire) begin
                  load_main_skid = 1'b1;
                  state_next     = ONE;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_next;
         if (load_main_in) begin
            main_q <= in_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline boundary: packs Memory-stage fields into a skid buffer and gates RegWrite by valid.
module memwb_skid_stage
   import memwb_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_W   = 6,
   parameter int unsigned RSRC_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              RegWriteM,
   input  logic [RSRC_W-1:0] ResultSrcM,
   input  logic [DATA_W-1:0] ALUOutM,
   input  logic [DATA_W-1:0] ReadDataM,
   input  logic [RD_W-1:0]   RDM,
   input  logic [DATA_W-1:0] PCPlus4M,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              RegWriteW,
   output logic [RSRC_W-1:0] ResultSrcW,
   output logic [DATA_W-1:0] ALUOutW,
   output logic [DATA_W-1:0] ReadDataW,
   output logic [RD_W-1:0]   RDW,
   output logic [DATA_W-1:0] PCPlus4W
);

   localparam int unsigned W = bundle_width(DATA_W, RD_W, RSRC_W);

   logic [W-1:0] in_data;
   logic [W-1:0] out_data;
   logic         reg_write_head;

   assign in_data = {RegWriteM, ResultSrcM, ALUOutM, ReadDataM, RDM, PCPlus4M};

   skid_buffer #(
      .W(W)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
   );

   assign {reg_write_head, ResultSrcW, ALUOutW, ReadDataW, RDW, PCPlus4W} = out_data;

   // Stale head contents after drain or flush must never reach the register file.
   assign RegWriteW = reg_write_head & out_valid;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Directed and random stimulus against a 2-deep FIFO reference model of the MEM/WB boundary.
module tb_memwb_skid_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic        RegWriteM, RegWriteW;
   logic [1:0]  ResultSrcM, ResultSrcW;
   logic [31:0] ALUOutM, ReadDataM, PCPlus4M, ALUOutW, ReadDataW, PCPlus4W;
   logic [5:0]  RDM, RDW;

   always #5 clk = ~clk;

   memwb_skid_stage #(.DATA_W(32), .RD_W(6), .RSRC_W(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUOutM(ALUOutM),
      .ReadDataM(ReadDataM), .RDM(RDM), .PCPlus4M(PCPlus4M),
      .out_valid(out_valid), .out_ready(out_ready),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUOutW(ALUOutW),
      .ReadDataW(ReadDataW), .RDW(RDW), .PCPlus4W(PCPlus4W)
   );

   typedef struct {
      logic        rw;
      logic [1:0]  rsrc;
      logic [31:0] alu;
      logic [31:0] rdat;
      logic [5:0]  rd;
      logic [31:0] pc;
   } bundle_t;

   bundle_t     q[$];
   bundle_t     disp;
   logic [31:0] emitted_pc[$];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bundle_t mk(input logic rw, input logic [31:0] alu, input logic [31:0] rdat,
                                  input logic [5:0] rd, input logic [31:0] pc);
      bundle_t b;
      b.rw = rw; b.rsrc = 2'($urandom_range(0, 3)); b.alu = alu; b.rdat = rdat; b.rd = rd; b.pc = pc;
      return b;
   endfunction

   function automatic bundle_t rb();
      return mk(1'($urandom_range(0, 1)), $urandom, $urandom, 6'($urandom_range(0, 63)), $urandom);
   endfunction

   // Enters at posedge+1: drive, compare against the model, then advance one clock.
   task automatic step(input logic iv, input bundle_t b, input logic ordy,
                       input logic fl, input logic rs);
      int n;
      bit ofire, ifire;
      in_valid = iv; out_ready = ordy; flush = fl; rst = rs;
      RegWriteM = b.rw; ResultSrcM = b.rsrc; ALUOutM = b.alu;
      ReadDataM = b.rdat; RDM = b.rd; PCPlus4M = b.pc;
      #1;
      n = q.size();
      check("out_valid", 64'(out_valid), 64'(n > 0));
      check("in_ready", 64'(in_ready), 64'(n < 2));
      check("reg_write_w", 64'(RegWriteW), 64'((n > 0) && disp.rw));
      check("result_src_w", 64'(ResultSrcW), 64'(disp.rsrc));
      check("alu_out_w", 64'(ALUOutW), 64'(disp.alu));
      check("read_data_w", 64'(ReadDataW), 64'(disp.rdat));
      check("rd_w", 64'(RDW), 64'(disp.rd));
      check("pc_plus4_w", 64'(PCPlus4W), 64'(disp.pc));
      if (rs) begin
         q.delete();
         disp = '{default: '0};
      end else if (fl) begin
         q.delete();
      end else begin
         ofire = (n > 0) && ordy;
         ifire = iv && (n < 2);
         if (ofire) begin
            emitted_pc.push_back(PCPlus4W);
            void'(q.pop_front());
         end
         if (ifire) q.push_back(b);
      end
      @(posedge clk);
      #1;
      if (q.size() > 0) disp = q[0];
   endtask

   initial begin
      bundle_t b;
      bit found;
      b = mk(1'b0, '0, '0, '0, '0);
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      RegWriteM = 1'b0; ResultSrcM = '0; ALUOutM = '0; ReadDataM = '0; RDM = '0; PCPlus4M = '0;
      disp = '{default: '0};
      repeat (2) @(posedge clk);
      #1;

      // reset mid-stall
      step(1, mk(1, 32'h11, 32'h1, 6'd1, 32'h4), 0, 0, 0);
      step(1, mk(1, 32'h22, 32'h2, 6'd2, 32'h8), 0, 0, 0);
      check("stall_in_ready", 64'(in_ready), 64'(0));
      step(1, mk(1, 32'h33, 32'h3, 6'd3, 32'hC), 0, 0, 1);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_reg_write", 64'(RegWriteW), 64'(0));
      check("rst_alu_out", 64'(ALUOutW), 64'(0));

      // streaming
      step(1, mk(1, 32'h10, 32'h0, 6'd1, 32'h100), 1, 0, 0);
      check("stream_alu0", 64'(ALUOutW), 64'h10);
      step(1, mk(1, 32'h20, 32'h0, 6'd2, 32'h104), 1, 0, 0);
      check("stream_alu1", 64'(ALUOutW), 64'h20);
      check("stream_in_ready", 64'(in_ready), 64'(1));
      step(1, mk(1, 32'h30, 32'h0, 6'd3, 32'h108), 1, 0, 0);
      check("stream_alu2", 64'(ALUOutW), 64'h30);
      step(0, b, 1, 0, 0);

      // backpressure
      step(1, mk(1, 32'h0, 32'h0, 6'd5, 32'h200), 0, 0, 0);
      step(1, mk(1, 32'h0, 32'h0, 6'd7, 32'h204), 0, 0, 0);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      step(1, mk(1, 32'h0, 32'h0, 6'd9, 32'h208), 0, 0, 0);
      check("bp_hold_rd", 64'(RDW), 64'd5);
      step(1, mk(1, 32'h0, 32'h0, 6'd9, 32'h208), 1, 0, 0);
      check("bp_rd7", 64'(RDW), 64'd7);
      step(1, mk(1, 32'h0, 32'h0, 6'd9, 32'h208), 1, 0, 0);
      check("bp_rd9", 64'(RDW), 64'd9);
      step(0, b, 1, 0, 0);

      // bubble gating
      step(0, mk(1, 32'hAA, 32'hBB, 6'd4, 32'h300), 1, 0, 0);
      check("bubble_rw0", 64'(RegWriteW), 64'(0));
      step(0, mk(1, 32'hAA, 32'hBB, 6'd4, 32'h300), 1, 0, 0);
      check("bubble_rw1", 64'(RegWriteW), 64'(0));

      // flush while full
      emitted_pc.delete();
      step(1, mk(1, 32'h0, 32'h0, 6'd1, 32'h104), 0, 0, 0);
      step(1, mk(1, 32'h0, 32'h0, 6'd2, 32'h108), 0, 0, 0);
      step(1, mk(1, 32'h0, 32'h0, 6'd3, 32'h10C), 0, 1, 0);
      check("flush_out_valid", 64'(out_valid), 64'(0));
      check("flush_reg_write", 64'(RegWriteW), 64'(0));
      repeat (3) step(0, b, 1, 0, 0);
      found = 1'b0;
      foreach (emitted_pc[i]) if (emitted_pc[i] == 32'h10C) found = 1'b1;
      check("flush_discard", 64'(found), 64'(0));

      // simultaneous fire in ONE
      step(1, mk(1, 32'h0, 32'h1234, 6'd8, 32'h400), 0, 0, 0);
      step(1, mk(1, 32'h0, 32'hDEADBEEF, 6'd9, 32'h404), 1, 0, 0);
      check("sim_out_valid", 64'(out_valid), 64'(1));
      check("sim_in_ready", 64'(in_ready), 64'(1));
      check("sim_read_data", 64'(ReadDataW), 64'hDEADBEEF);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), rb(), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 79) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
